// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Sequences one shared decoder across NUM_DIGITS digits with a blank gap per slot.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic                    lz_blank_en,
    output logic [3:0]              dig_data,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int CW          = $clog2(REFRESH_DIV);
    localparam int IW          = $clog2(NUM_DIGITS);
    localparam int SHOW_CYCLES = REFRESH_DIV - BLANK_CYCLES;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {S_OFF, S_BLANK, S_SHOW} state_t;

    state_t                      r_state;
    logic [CW-1:0]               r_cnt;
    logic [IW-1:0]               r_idx;
    logic [NUM_DIGITS-1:0][3:0]  r_pend;
    logic                        r_pend_valid;
    logic [NUM_DIGITS-1:0][3:0]  r_active;
    logic [NUM_DIGITS-1:0]       r_an;
    logic [3:0]                  r_dig;
    logic                        r_fd;

    state_t                      w_state_nxt;
    logic [CW-1:0]               w_cnt_nxt;
    logic [IW-1:0]               w_idx_nxt;
    logic                        w_frame_start;
    logic [NUM_DIGITS-1:0][3:0]  w_data;
    logic [NUM_DIGITS-1:0][3:0]  w_pend_nxt;
    logic                        w_pend_valid_nxt;
    logic [NUM_DIGITS-1:0][3:0]  w_active_nxt;
    logic [NUM_DIGITS:0]         w_zero_above;
    logic [NUM_DIGITS-1:0][3:0]  w_eff;
    logic [NUM_DIGITS-1:0]       w_an_nxt;
    logic [3:0]                  w_dig_nxt;
    logic                        w_fd_nxt;

    assign w_data     = data_in;
    assign an         = r_an;
    assign dig_data   = r_dig;
    assign frame_done = r_fd;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CW'(1);
        w_idx_nxt     = r_idx;
        w_frame_start = 1'b0;
        if (!enable) begin
            w_state_nxt = S_OFF;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_state_nxt   = S_BLANK;
                    w_cnt_nxt     = '0;
                    w_idx_nxt     = '0;
                    w_frame_start = 1'b1;
                end
                S_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_nxt = S_SHOW;
                        w_cnt_nxt   = '0;
                    end
                end
                S_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_state_nxt = S_BLANK;
                        w_cnt_nxt   = '0;
                        if (r_idx == IDX_LAST) begin
                            w_idx_nxt     = '0;
                            w_frame_start = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + IW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_OFF;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // A load coinciding with frame start bypasses pending so it shows this frame.
    always_comb begin
        w_pend_nxt       = load ? w_data : r_pend;
        w_pend_valid_nxt = r_pend_valid;
        w_active_nxt     = r_active;
        if (w_frame_start) begin
            if (load)
                w_active_nxt = w_data;
            else if (r_pend_valid)
                w_active_nxt = r_pend;
            w_pend_valid_nxt = 1'b0;
        end else if (load) begin
            w_pend_valid_nxt = 1'b1;
        end
    end

    always_comb begin
        w_zero_above[NUM_DIGITS] = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--)
            w_zero_above[k] = w_zero_above[k+1] && (w_active_nxt[k] == 4'h0);
        for (int k = 0; k < NUM_DIGITS; k++)
            w_eff[k] = (lz_blank_en && k != 0 && w_zero_above[k]) ? 4'hF : w_active_nxt[k];
    end

    // Decoder input is latched on slot entry so it settles during the blank gap.
    always_comb begin
        w_an_nxt = '1;
        if (w_state_nxt == S_SHOW)
            w_an_nxt[w_idx_nxt] = 1'b0;
        w_dig_nxt = r_dig;
        if (w_state_nxt == S_OFF)
            w_dig_nxt = 4'hF;
        else if (w_state_nxt == S_BLANK && r_state != S_BLANK)
            w_dig_nxt = w_eff[w_idx_nxt];
        w_fd_nxt = (w_state_nxt == S_SHOW) && (w_idx_nxt == IDX_LAST) &&
                   (w_cnt_nxt == SHOW_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_OFF;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_pend       <= '1;
            r_pend_valid <= 1'b0;
            r_active     <= '1;
            r_an         <= '1;
            r_dig        <= 4'hF;
            r_fd         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_active     <= w_active_nxt;
            r_an         <= w_an_nxt;
            r_dig        <= w_dig_nxt;
            r_fd         <= w_fd_nxt;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: expected per-cycle outputs are queued per
// frame and popped against the DUT one cycle at a time.
module tb_seg_scan_ctrl;
    localparam int N  = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic          clk = 1'b0;
    logic          rst_n, enable, load, lz_blank_en;
    logic [4*N-1:0] data_in;
    logic [3:0]    dig_data;
    logic [N-1:0]  an;
    logic          frame_done;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] dig;
        logic       fd;
    } exp_t;

    exp_t  q[$];
    int    vectors = 0;
    int    errors  = 0;
    string tag     = "init";

    seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
        .data_in(data_in), .lz_blank_en(lz_blank_en),
        .dig_data(dig_data), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the first 'limit' cycles of a frame showing v.
    function automatic void push_frame(input logic [15:0] v, input bit lz, input int limit);
        int   n;
        bit   zero_above;
        logic [3:0] d;
        exp_t e;
        n = 0;
        for (int k = 0; k < N; k++) begin
            d = v[4*k +: 4];
            zero_above = 1'b1;
            for (int j = k; j < N; j++)
                if (v[4*j +: 4] != 4'h0) zero_above = 1'b0;
            if (lz && k > 0 && zero_above) d = 4'hF;
            for (int c = 0; c < RD; c++) begin
                e.an  = (c < BC) ? 4'b1111 : ~(4'b0001 << k);
                e.dig = d;
                e.fd  = (k == N - 1) && (c == RD - 1);
                if (n < limit) q.push_back(e);
                n++;
            end
        end
    endfunction

    task automatic check_next();
        exp_t e;
        vectors++;
        if (q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, an/dig/fd=%b/%h/%b", tag, an, dig_data, frame_done);
        end else begin
            e = q.pop_front();
            assert ({an, dig_data, frame_done} === {e.an, e.dig, e.fd}) else begin
                errors++;
                $error("FAIL %s an/dig/fd=%b/%h/%b expected %b/%h/%b",
                       tag, an, dig_data, frame_done, e.an, e.dig, e.fd);
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check_next();
        end
    endtask

    task automatic check_idle(input string t);
        vectors++;
        assert ({an, dig_data, frame_done} === {4'b1111, 4'hF, 1'b0}) else begin
            errors++;
            $error("FAIL %s an/dig/fd=%b/%h/%b expected 1111/f/0", t, an, dig_data, frame_done);
        end
    endtask

    // Full frame whose first edge is a frame start, optionally loading on that edge.
    task automatic frame_at_start(input logic [15:0] v, input bit lz, input bit do_load);
        lz_blank_en = lz;
        if (do_load) begin
            load    = 1'b1;
            data_in = v;
        end
        push_frame(v, lz, RD * N);
        drain(1);
        load = 1'b0;
        drain(RD * N - 1);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; load = 1'b0; data_in = '0; lz_blank_en = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("reset");
        end

        rst_n = 1'b1; enable = 1'b0;
        tick();
        check_idle("off_after_reset");
        load = 1'b1; data_in = 16'h1234;
        tick();
        load = 1'b0;
        check_idle("off_load");

        tag = "basic_scan";
        enable = 1'b1;
        push_frame(16'h1234, 1'b0, RD * N);
        push_frame(16'h1234, 1'b0, RD * N);
        drain(2 * RD * N);

        tag = "lz_0050";
        frame_at_start(16'h0050, 1'b1, 1'b1);
        tag = "lz_0000";
        frame_at_start(16'h0000, 1'b1, 1'b1);
        tag = "nolz_0000";
        frame_at_start(16'h0000, 1'b0, 1'b0);

        tag = "load_at_start";
        frame_at_start(16'h1234, 1'b0, 1'b1);
        tag = "midframe_load";
        push_frame(16'h1234, 1'b0, RD * N);
        drain(RD + 3);
        load = 1'b1; data_in = 16'h9999;
        drain(1);
        load = 1'b0;
        drain(RD * N - RD - 4);
        tag = "next_frame_9999";
        push_frame(16'h9999, 1'b0, RD * N);
        drain(RD * N);

        tag = "pre_disable";
        push_frame(16'h9999, 1'b0, 2 * RD + BC + 2);
        drain(2 * RD + BC + 2);
        enable = 1'b0;
        tick();
        check_idle("disable");
        tick();
        check_idle("disabled_hold");
        tag = "reenable";
        enable = 1'b1;
        push_frame(16'h9999, 1'b0, RD * N);
        drain(RD * N);

        tag = "pre_reset";
        push_frame(16'h9999, 1'b0, 3 * RD + BC + 3);
        drain(5);
        load = 1'b1; data_in = 16'h5678;
        drain(1);
        load = 1'b0;
        drain(3 * RD + BC + 3 - 6);
        rst_n = 1'b0;
        tick();
        check_idle("reset_mid_show");
        rst_n = 1'b1;
        tag = "post_reset_blank";
        push_frame(16'hFFFF, 1'b0, RD * N);
        drain(RD * N);
        tag = "post_reset_load";
        frame_at_start(16'h0042, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
